// File: rtl/intbus_trace_pkg.sv
// Shared types for the int_bus trace capture block.
//  - Def*        : default geometry used by the top and by anything decoding entries
//  - trace_type_e : entry type code stored in the top two bits of an entry
//  - trace_state_e: capture FSM state, also the value driven on state_o
//  - trace_entry_t: decoded view of one trace entry {type, addr, data, ts}
package intbus_trace_pkg;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefTsW   = 16;
  localparam int unsigned DefDepth = 64;

  typedef enum logic [1:0] {
    TypeNone = 2'b00,
    TypeWr   = 2'b01,
    TypeRd   = 2'b10
  } trace_type_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StPost = 2'd2,
    StDone = 2'd3
  } trace_state_e;

  typedef struct packed {
    trace_type_e         typ;
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] data;
    logic [DefTsW-1:0]   ts;
  } trace_entry_t;

endpackage

// File: rtl/intbus_trace_capture_if.sv
// Observed int_bus signals as seen by the trace monitor.
//  master: the side that drives the bus (bus fabric or a testbench)
//  slave : the passive monitor, which only samples
interface intbus_trace_capture_if
  import intbus_trace_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) ();

  logic [ADDR_W-1:0] mon_addr;
  logic [DATA_W-1:0] mon_wdata;
  logic [DATA_W-1:0] mon_rdata;
  logic              mon_rvalid;
  logic              mon_wr;
  logic              mon_rd;

  modport master (
    output mon_addr, mon_wdata, mon_rdata, mon_rvalid, mon_wr, mon_rd
  );

  modport slave (
    input mon_addr, mon_wdata, mon_rdata, mon_rvalid, mon_wr, mon_rd
  );

endinterface

// File: rtl/trace_ram.sv
// Simple dual-port trace RAM: one write port, one read port with a registered output.
//  clk_i   : clock
//  we_i    : write enable, waddr_i/wdata_i : write address/data
//  re_i    : read enable,  raddr_i         : read address
//  rdata_o : read data, valid the cycle after re_i
// The array has no reset so it maps onto block RAM.
module trace_ram #(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned WIDTH = 66,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/intbus_trace_capture.sv
// Passive int_bus trace capture: records completed writes and reads, with timestamps, into a
// circular trace RAM and freezes on an address-match trigger plus a programmable post count.
//  clk, reset           : clock, asynchronous active-high reset
//  mon                  : observed bus (slave modport)
//  arm                  : clear trace and start capture
//  trig_addr/trig_mask  : trigger address and compare mask (1 = bit compared)
//  trig_wr_en/trig_rd_en: which entry types may trigger
//  post_cnt             : entries stored after the trigger entry
//  rd_idx/rd_req        : readout index (0 = oldest) and strobe
//  rd_valid/rd_entry    : readout result, one cycle after rd_req
//  state_o, n_entries, drop_cnt : status
module intbus_trace_capture
  import intbus_trace_pkg::*;
#(
  parameter  int unsigned ADDR_W = DefAddrW,
  parameter  int unsigned DATA_W = DefDataW,
  parameter  int unsigned DEPTH  = DefDepth,
  parameter  int unsigned TS_W   = DefTsW,
  localparam int unsigned IdxW   = $clog2(DEPTH),
  localparam int unsigned EntW   = 2 + ADDR_W + DATA_W + TS_W
) (
  input  logic              clk,
  input  logic              reset,
  intbus_trace_capture_if.slave mon,
  input  logic              arm,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic [ADDR_W-1:0] trig_mask,
  input  logic              trig_wr_en,
  input  logic              trig_rd_en,
  input  logic [IdxW-1:0]   post_cnt,
  input  logic [IdxW-1:0]   rd_idx,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [EntW-1:0]   rd_entry,
  output logic [1:0]        state_o,
  output logic [IdxW:0]     n_entries,
  output logic [7:0]        drop_cnt
);

  trace_state_e      state_q, state_d;
  logic [TS_W-1:0]   ts_q;
  logic [IdxW-1:0]   wr_ptr_q, wr_ptr_d, post_left_q, post_left_d;
  logic [IdxW:0]     n_q, n_d;
  logic [7:0]        drop_q, drop_d;
  logic              skid_vld_q, skid_vld_d;
  logic [EntW-1:0]   skid_q, skid_d;
  logic              rdl_vld_q, rdl_vld_d;
  logic [ADDR_W-1:0] rdl_addr_q, rdl_addr_d;
  logic [TS_W-1:0]   rdl_ts_q, rdl_ts_d;
  logic              rd_valid_q, idx_ok_q;

  logic              capture, wr_ev, rd_ev, rd_cpl, we, is_trig;
  logic [EntW-1:0]   wr_ent, cpl_ent, wdat, ram_rdata;
  logic [1:0]        drop_inc;
  logic [8:0]        drop_sum;
  logic [IdxW-1:0]   oldest, raddr;

  // Arm wins over capture, so events in the arm cycle never reach the RAM.
  assign capture = (state_q == StPre || state_q == StPost) && !arm;
  assign wr_ev   = capture && mon.mon_wr;
  assign rd_ev   = capture && mon.mon_rd;
  assign rd_cpl  = capture && mon.mon_rvalid && rdl_vld_q;
  assign wr_ent  = {TypeWr, mon.mon_addr, mon.mon_wdata, ts_q};
  assign cpl_ent = {TypeRd, rdl_addr_q, mon.mon_rdata, rdl_ts_q};

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    n_d         = n_q;
    post_left_d = post_left_q;
    skid_vld_d  = skid_vld_q;
    skid_d      = skid_q;
    rdl_vld_d   = rdl_vld_q;
    rdl_addr_d  = rdl_addr_q;
    rdl_ts_d    = rdl_ts_q;
    we          = 1'b0;
    wdat        = cpl_ent;
    drop_inc    = 2'd0;
    is_trig     = 1'b0;

    // Read latch: a completion frees it; a new rd (re)loads it, losing any pending rd.
    if (rd_cpl) rdl_vld_d = 1'b0;
    if (rd_ev) begin
      rdl_vld_d  = 1'b1;
      rdl_addr_d = mon.mon_addr;
      rdl_ts_d   = ts_q;
      if (rdl_vld_q && !rd_cpl) drop_inc = drop_inc + 2'd1;
    end

    // Single write port: completion > skid > direct write. A write arriving while the skid
    // is occupied has nowhere to go and is dropped.
    if (rd_cpl) begin
      we = 1'b1;
      if (wr_ev) begin
        if (skid_vld_q) begin
          drop_inc = drop_inc + 2'd1;
        end else begin
          skid_vld_d = 1'b1;
          skid_d     = wr_ent;
        end
      end
    end else if (skid_vld_q) begin
      we         = 1'b1;
      wdat       = skid_q;
      skid_vld_d = 1'b0;
      if (wr_ev) drop_inc = drop_inc + 2'd1;
    end else if (wr_ev) begin
      we   = 1'b1;
      wdat = wr_ent;
    end

    if (we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (n_q != (IdxW+1)'(DEPTH)) n_d = n_q + 1'b1;
      is_trig = (((wdat[EntW-3 -: ADDR_W] ^ trig_addr) & trig_mask) == '0) &&
                ((wdat[EntW-1 -: 2] == TypeWr && trig_wr_en) ||
                 (wdat[EntW-1 -: 2] == TypeRd && trig_rd_en));
    end

    case (state_q)
      StPre: begin
        if (is_trig) begin
          post_left_d = post_cnt;
          state_d     = (post_cnt == '0) ? StDone : StPost;
        end
      end
      StPost: begin
        if (we) begin
          post_left_d = post_left_q - 1'b1;
          if (post_left_q == IdxW'(1)) state_d = StDone;
        end
      end
      default: ;
    endcase

    // Outside capture (and in the arm cycle) nothing may stay pending.
    if (!capture) begin
      skid_vld_d = 1'b0;
      rdl_vld_d  = 1'b0;
    end

    drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    if (arm) begin
      state_d  = StPre;
      wr_ptr_d = '0;
      n_d      = '0;
      drop_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      post_left_q <= '0;
      n_q         <= '0;
      drop_q      <= '0;
      skid_vld_q  <= 1'b0;
      skid_q      <= '0;
      rdl_vld_q   <= 1'b0;
      rdl_addr_q  <= '0;
      rdl_ts_q    <= '0;
      rd_valid_q  <= 1'b0;
      idx_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_q + 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      post_left_q <= post_left_d;
      n_q         <= n_d;
      drop_q      <= drop_d;
      skid_vld_q  <= skid_vld_d;
      skid_q      <= skid_d;
      rdl_vld_q   <= rdl_vld_d;
      rdl_addr_q  <= rdl_addr_d;
      rdl_ts_q    <= rdl_ts_d;
      rd_valid_q  <= rd_req;
      idx_ok_q    <= ({1'b0, rd_idx} < n_q);
    end
  end

  // Once the buffer has wrapped, the next slot to be overwritten holds the oldest entry.
  assign oldest = (n_q == (IdxW+1)'(DEPTH)) ? wr_ptr_q : '0;
  assign raddr  = oldest + rd_idx;

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdat),
    .re_i    (rd_req),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    rd_entry = '0;
    if (rd_valid_q) begin
      rd_entry = ram_rdata;
      if (!idx_ok_q) rd_entry[EntW-1 -: 2] = TypeNone;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign state_o   = state_q;
  assign n_entries = n_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_intbus_trace_capture.sv
// Directed bench for intbus_trace_capture with hand-computed expectations.
module tb_intbus_trace_capture;
  import intbus_trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic [15:0] trig_addr = '0;
  logic [15:0] trig_mask = 16'hFFFF;
  logic        trig_wr_en = 1'b0;
  logic        trig_rd_en = 1'b0;
  logic [5:0]  post_cnt = '0;
  logic [5:0]  rd_idx = '0;
  logic        rd_req = 1'b0;
  logic        rd_valid;
  logic [65:0] rd_entry;
  logic [1:0]  state_o;
  logic [6:0]  n_entries;
  logic [7:0]  drop_cnt;
  logic [15:0] ts_ref;
  trace_entry_t ent;

  int n_checks = 0;
  int n_errors = 0;

  intbus_trace_capture_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  intbus_trace_capture dut (
    .clk        (clk),
    .reset      (reset),
    .mon        (bus),
    .arm        (arm),
    .trig_addr  (trig_addr),
    .trig_mask  (trig_mask),
    .trig_wr_en (trig_wr_en),
    .trig_rd_en (trig_rd_en),
    .post_cnt   (post_cnt),
    .rd_idx     (rd_idx),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .rd_entry   (rd_entry),
    .state_o    (state_o),
    .n_entries  (n_entries),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference timestamp: cycles since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) ts_ref <= '0;
    else       ts_ref <= ts_ref + 16'd1;
  end

  assign ent = rd_entry;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d, output logic [15:0] ts);
    bus.mon_addr  = a;
    bus.mon_wdata = d;
    bus.mon_wr    = 1'b1;
    ts            = ts_ref;
    tick();
    bus.mon_wr = 1'b0;
  endtask

  task automatic read_entry(input logic [5:0] idx);
    rd_idx = idx;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  logic [15:0] ts0, ts_rd, ts_x;

  initial begin
    bus.mon_addr = '0; bus.mon_wdata = '0; bus.mon_rdata = '0;
    bus.mon_rvalid = 1'b0; bus.mon_wr = 1'b0; bus.mon_rd = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state; events in IDLE are ignored
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_n", 64'(n_entries), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_valid", 64'(rd_valid), 64'd0);
    bus_wr(16'h0001, 32'h1, ts_x);
    check("idle_n", 64'(n_entries), 64'd0);

    // 1: trigger on 0x14 with one post entry
    trig_addr = 16'h0014; trig_mask = 16'hFFFF; trig_wr_en = 1'b1; trig_rd_en = 1'b0;
    post_cnt = 6'd1;
    do_arm();
    check("t1_pre", 64'(state_o), 64'd1);
    bus_wr(16'h0010, 32'h1111_0010, ts0);
    check("t1_pre2", 64'(state_o), 64'd1);
    bus_wr(16'h0014, 32'h1111_0014, ts_x);
    check("t1_post", 64'(state_o), 64'd2);
    bus_wr(16'h0018, 32'h1111_0018, ts_x);
    check("t1_done", 64'(state_o), 64'd3);
    check("t1_n", 64'(n_entries), 64'd3);
    bus_wr(16'h001C, 32'h1111_001C, ts_x);
    check("t1_frozen_n", 64'(n_entries), 64'd3);
    read_entry(6'd0);
    check("t1_rv", 64'(rd_valid), 64'd1);
    check("t1_typ", 64'(ent.typ), 64'(TypeWr));
    check("t1_addr", 64'(ent.addr), 64'h10);
    check("t1_data", 64'(ent.data), 64'h1111_0010);
    check("t1_ts", 64'(ent.ts), 64'(ts0));
    tick();
    check("t1_rv_low", 64'(rd_valid), 64'd0);
    read_entry(6'd2);
    check("t1_idx2", 64'(ent.addr), 64'h18);

    // 6: index beyond stored entries
    read_entry(6'd5);
    check("t6_rv", 64'(rd_valid), 64'd1);
    check("t6_typ", 64'(ent.typ), 64'(TypeNone));

    // 2: read with completion three cycles later, trigger on the read
    trig_wr_en = 1'b0; trig_rd_en = 1'b1; trig_addr = 16'h0020; post_cnt = 6'd0;
    do_arm();
    bus.mon_addr = 16'h0020; bus.mon_rd = 1'b1; ts_rd = ts_ref;
    tick();
    bus.mon_rd = 1'b0; bus.mon_addr = 16'h0099;
    tick(); tick();
    bus.mon_rvalid = 1'b1; bus.mon_rdata = 32'h0000_CAFE;
    tick();
    bus.mon_rvalid = 1'b0;
    check("t2_done", 64'(state_o), 64'd3);
    check("t2_n", 64'(n_entries), 64'd1);
    read_entry(6'd0);
    check("t2_typ", 64'(ent.typ), 64'(TypeRd));
    check("t2_addr", 64'(ent.addr), 64'h20);
    check("t2_data", 64'(ent.data), 64'hCAFE);
    check("t2_ts", 64'(ent.ts), 64'(ts_rd));

    // 3: completion collides with a write, then a third event overflows the skid
    trig_wr_en = 1'b0; trig_rd_en = 1'b0;
    do_arm();
    bus.mon_addr = 16'h0040; bus.mon_rd = 1'b1;
    tick();
    bus.mon_rd = 1'b0;
    bus.mon_rvalid = 1'b1; bus.mon_rdata = 32'h0000_BEEF;
    bus.mon_wr = 1'b1; bus.mon_addr = 16'h0030; bus.mon_wdata = 32'h3030;
    tick();
    bus.mon_rvalid = 1'b0;
    check("t3_drop0", 64'(drop_cnt), 64'd0);
    bus.mon_addr = 16'h0034; bus.mon_wdata = 32'h3434;
    tick();
    bus.mon_wr = 1'b0;
    check("t3_drop1", 64'(drop_cnt), 64'd1);
    tick();
    check("t3_n", 64'(n_entries), 64'd2);
    // Second rd before rvalid overwrites the latch
    bus.mon_addr = 16'h0044; bus.mon_rd = 1'b1;
    tick();
    bus.mon_addr = 16'h0048;
    tick();
    bus.mon_rd = 1'b0;
    check("t3_drop2", 64'(drop_cnt), 64'd2);
    bus.mon_rvalid = 1'b1; bus.mon_rdata = 32'h4848;
    tick();
    bus.mon_rvalid = 1'b0;
    read_entry(6'd0);
    check("t3_i0_typ", 64'(ent.typ), 64'(TypeRd));
    check("t3_i0_data", 64'(ent.data), 64'hBEEF);
    read_entry(6'd1);
    check("t3_i1_typ", 64'(ent.typ), 64'(TypeWr));
    check("t3_i1_addr", 64'(ent.addr), 64'h30);
    read_entry(6'd2);
    check("t3_i2_addr", 64'(ent.addr), 64'h48);
    check("t3_i2_data", 64'(ent.data), 64'h4848);

    // 4: wrap with 100 writes, then trigger with no post entries
    trig_wr_en = 1'b0; post_cnt = 6'd0;
    do_arm();
    for (int i = 1; i <= 100; i++) bus_wr(16'h0100 + 16'(i), 32'(i), ts_x);
    check("t4_n", 64'(n_entries), 64'd64);
    check("t4_pre", 64'(state_o), 64'd1);
    trig_addr = 16'hABCD; trig_wr_en = 1'b1;
    bus_wr(16'hABCD, 32'hDEAD_BEEF, ts_x);
    check("t4_done", 64'(state_o), 64'd3);
    read_entry(6'd0);
    check("t4_i0_addr", 64'(ent.addr), 64'h126);
    check("t4_i0_data", 64'(ent.data), 64'd38);
    read_entry(6'd63);
    check("t4_i63_addr", 64'(ent.addr), 64'hABCD);
    check("t4_i63_data", 64'(ent.data), 64'hDEAD_BEEF);

    // 5: re-arm in POST, then asynchronous reset mid-PRE
    trig_addr = 16'h0050; trig_wr_en = 1'b1; post_cnt = 6'd5;
    do_arm();
    bus_wr(16'h0050, 32'h50, ts_x);
    check("t5_post", 64'(state_o), 64'd2);
    bus_wr(16'h0054, 32'h54, ts_x);
    arm = 1'b1; bus.mon_wr = 1'b1; bus.mon_addr = 16'h0060;
    tick();
    arm = 1'b0; bus.mon_wr = 1'b0;
    check("t5_rearm_st", 64'(state_o), 64'd1);
    check("t5_rearm_n", 64'(n_entries), 64'd0);
    bus_wr(16'h0064, 32'h64, ts_x);
    check("t5_n1", 64'(n_entries), 64'd1);
    bus.mon_addr = 16'h0070; bus.mon_rd = 1'b1;
    tick();
    bus.mon_addr = 16'h0074;
    tick();
    bus.mon_rd = 1'b0;
    rd_req = 1'b1; rd_idx = 6'd0;
    tick();
    rd_req = 1'b0;
    check("t5_pre_drop", 64'(drop_cnt), 64'd1);
    check("t5_pre_rv", 64'(rd_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_state", 64'(state_o), 64'd0);
    check("t5_rst_n", 64'(n_entries), 64'd0);
    check("t5_rst_drop", 64'(drop_cnt), 64'd0);
    check("t5_rst_rv", 64'(rd_valid), 64'd0);
    check("t5_rst_entry", 64'(rd_entry == '0), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    check("t5_after_state", 64'(state_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
